coor_track_filter: RTL

- Sits directly downstream of the image-processing top. Consumes its per-frame target centroid (x_coor, y_coor, coor_valid_flag) plus the frame vsync.
- Produces a moving-average, centre-referenced signed pointing error for the PID/servo stage.
- Tracks target lock and declares the target lost after a run of frames with no valid centroid.

---
 rtl/coor_track_filter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/coor_track_filter.sv
// Centroid tracking filter: N-deep moving average of the per-frame target centroid,
// centre-referenced signed pointing error with deadband, and lock/loss tracking.
module coor_track_filter #(
    parameter logic [9:0] CENTER_X    = 10'd400,
    parameter logic [9:0] CENTER_Y    = 10'd240,
    parameter int         AVG_SHIFT   = 2,
    parameter int         LOST_FRAMES = 8,
    parameter int         DEADBAND    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  logic [9:0]  x_coor,
    input  logic [9:0]  y_coor,
    input  logic        coor_valid_flag,
    output logic [10:0] err_x,
    output logic [10:0] err_y,
    output logic        err_valid,
    output logic [9:0]  x_avg,
    output logic [9:0]  y_avg,
    output logic        target_lock,
    output logic        lost_pulse
);

    localparam int N  = 1 << AVG_SHIFT;
    localparam int SW = 10 + AVG_SHIFT;
    localparam int FW = AVG_SHIFT + 1;
    localparam logic [FW-1:0]     FILL_FULL = FW'(N);
    localparam logic [7:0]        LOST_CNT  = 8'(LOST_FRAMES);
    localparam logic signed [11:0] DB       = 12'(DEADBAND);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    state_t          state_q, state_d;
    logic            vsync_d;
    logic            seen;
    logic [7:0]      miss_cnt;
    logic [FW-1:0]   fill_cnt;
    logic [9:0]      win_x [N];
    logic [9:0]      win_y [N];
    logic [SW-1:0]   sum_x, sum_y;
    logic            calc_pend;

    logic            vs_rise, seen_eff, lost, accept, fire;
    logic [7:0]      miss_inc;
    logic [FW-1:0]   fill_next;
    logic [9:0]      avg_x, avg_y;

    function automatic logic [10:0] center_err(input logic [9:0] avg, input logic [9:0] center);
        logic signed [11:0] e;
        e = $signed({2'b00, avg}) - $signed({2'b00, center});
        if (e >= -DB && e <= DB) return '0;
        return e[10:0];
    endfunction

    // A strobe coincident with the vsync edge belongs to the frame that is ending.
    assign vs_rise   = vsync_i & ~vsync_d;
    assign seen_eff  = seen | coor_valid_flag;
    assign miss_inc  = (miss_cnt == 8'hFF) ? 8'hFF : miss_cnt + 8'd1;
    assign lost      = vs_rise && !seen_eff && (miss_inc == LOST_CNT) && (state_q != IDLE);
    assign accept    = coor_valid_flag && !lost;
    assign fill_next = fill_cnt + FW'(1);
    assign avg_x     = sum_x[SW-1:AVG_SHIFT];
    assign avg_y     = sum_y[SW-1:AVG_SHIFT];
    assign target_lock = (state_q == TRACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        fire    = 1'b0;
        if (lost) begin
            state_d = IDLE;
        end else if (accept) begin
            if (state_q == TRACK) begin
                fire = 1'b1;
            end else if (fill_next == FILL_FULL) begin
                state_d = TRACK;
                fire    = 1'b1;
            end else begin
                state_d = ACQUIRE;
            end
        end
    end

    // The window starts from zeros, so sum + new - oldest also covers the fill phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            seen       <= 1'b0;
            miss_cnt   <= '0;
            fill_cnt   <= '0;
            sum_x      <= '0;
            sum_y      <= '0;
            calc_pend  <= 1'b0;
            err_valid  <= 1'b0;
            err_x      <= '0;
            err_y      <= '0;
            x_avg      <= '0;
            y_avg      <= '0;
            lost_pulse <= 1'b0;
            // NOTE: the window is a handful of flops, not a RAM, so it can and must be reset.
            for (int i = 0; i < N; i++) begin
                win_x[i] <= '0;
                win_y[i] <= '0;
            end
        end else begin
            vsync_d    <= vsync_i;
            lost_pulse <= lost;
            calc_pend  <= fire;

            if (vs_rise)              seen <= 1'b0;
            else if (coor_valid_flag) seen <= 1'b1;

            if (lost)         miss_cnt <= '0;
            else if (vs_rise) miss_cnt <= seen_eff ? 8'd0 : miss_inc;

            if (lost) begin
                fill_cnt <= '0;
                sum_x    <= '0;
                sum_y    <= '0;
                for (int i = 0; i < N; i++) begin
                    win_x[i] <= '0;
                    win_y[i] <= '0;
                end
            end else if (accept) begin
                sum_x <= sum_x + SW'(x_coor) - SW'(win_x[N-1]);
                sum_y <= sum_y + SW'(y_coor) - SW'(win_y[N-1]);
                win_x[0] <= x_coor;
                win_y[0] <= y_coor;
                for (int i = 1; i < N; i++) begin
                    win_x[i] <= win_x[i-1];
                    win_y[i] <= win_y[i-1];
                end
                if (state_q != TRACK) fill_cnt <= fill_next;
            end

            // Second stage reads the sum before any same-edge loss clear takes effect.
            err_valid <= calc_pend;
            if (calc_pend) begin
                x_avg <= avg_x;
                y_avg <= avg_y;
                err_x <= center_err(avg_x, CENTER_X);
                err_y <= center_err(avg_y, CENTER_Y);
            end
        end
    end

endmodule
